// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Two-wide in / two-wide out circular instruction queue between fetch and
//   decode. Entries leave in strict program order; slot 0 is always the older
//   entry on both sides.
//
// Parameters
//   DEPTH        number of entries (power of two, >= 4)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     [1:0]  fetch slot valid (slot 1 only counts if slot 0 is valid)
//   in_pc        [1:0][31:0]  slot PC
//   in_instr     [1:0][31:0]  slot instruction word
//   can_proceed  [1:0]  space grant to fetch (registered count only)
//   flush        branch redirect: drop all contents, block enqueue this cycle
//   out_valid    [1:0]  entry presented to decode
//   out_pc       [1:0][31:0]  presented PC (don't-care while out_valid is 0)
//   out_instr    [1:0][31:0]  presented instruction word
//   out_ready    [1:0]  decode accepts slot (slot 1 only counts if slot 0 taken)
//
// Handshake: a slot transfers on a cycle where its valid and its grant
// (can_proceed / out_ready) are both high; slot 1 transfers only in a cycle
// where slot 0 transfers too, so transfers are always a prefix {0} or {0,1}.
//
// Configuration
//   FETCH_QUEUE_BYPASS_EN  when defined, an empty queue forwards accepted
//   fetch slots straight to the outputs in the same cycle; slots decode does
//   not take are written into storage in order.
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       in_valid,
    input  logic [1:0][31:0] in_pc,
    input  logic [1:0][31:0] in_instr,
    output logic [1:0]       can_proceed,
    input  logic             flush,
    output logic [1:0]       out_valid,
    output logic [1:0][31:0] out_pc,
    output logic [1:0][31:0] out_instr,
    input  logic [1:0]       out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;

    // Storage is intentionally not reset; out_* data is only meaningful
    // alongside out_valid.
    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

    logic       a0, a1, d0, d1;
    logic [1:0] n_in, n_out, n_byp, n_deq, n_wr;
    logic       byp_mode;
    logic       we0, we1;
    logic [AW-1:0] waddr0, waddr1;
    logic [31:0]   wpc0, winstr0;

    // Grant depends on registered occupancy only, so fetch never sees a
    // combinational path from this cycle's inputs.
    assign can_proceed[0] = (count_q <= CW'(DEPTH - 1));
    assign can_proceed[1] = (count_q <= CW'(DEPTH - 2));

    always_comb begin
        // Acceptance; gated by reset so nothing leaks out while held in reset.
        a0 = in_valid[0] & can_proceed[0] & ~flush & reset;
        a1 = a0 & in_valid[1] & can_proceed[1];
        n_in = {1'b0, a0} + {1'b0, a1};

`ifdef FETCH_QUEUE_BYPASS_EN
        byp_mode = (count_q == '0) & ~flush;
`else
        byp_mode = 1'b0;
`endif

        out_valid    = 2'b00;
        out_pc[0]    = pc_mem_q[head_q];
        out_pc[1]    = pc_mem_q[head_q + AW'(1)];
        out_instr[0] = instr_mem_q[head_q];
        out_instr[1] = instr_mem_q[head_q + AW'(1)];

        if (byp_mode) begin
            out_valid = {a1, a0};
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (!flush) begin
            out_valid[0] = (count_q >= CW'(1));
            out_valid[1] = (count_q >= CW'(2));
        end

        d0    = out_valid[0] & out_ready[0];
        d1    = d0 & out_valid[1] & out_ready[1];
        n_out = {1'b0, d0} + {1'b0, d1};

        // In bypass mode the taken slots never touch storage, so they do not
        // move head; the remaining accepted slots are written behind them.
        n_byp = byp_mode ? n_out : 2'd0;
        n_deq = byp_mode ? 2'd0  : n_out;
        n_wr  = n_in - n_byp;

        we0     = (n_wr != 2'd0);
        we1     = (n_wr == 2'd2);
        waddr0  = tail_q;
        waddr1  = tail_q + AW'(1);
        // First written slot is the oldest accepted slot not already taken.
        wpc0    = (n_byp == 2'd1) ? in_pc[1]    : in_pc[0];
        winstr0 = (n_byp == 2'd1) ? in_instr[1] : in_instr[0];

        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            count_d = count_q + CW'(n_wr) - CW'(n_deq);
            head_d  = head_q + AW'(n_deq);
            tail_d  = tail_q + AW'(n_wr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) begin
            pc_mem_q[waddr0]    <= wpc0;
            instr_mem_q[waddr0] <= winstr0;
        end
        if (we1) begin
            pc_mem_q[waddr1]    <= in_pc[1];
            instr_mem_q[waddr1] <= in_instr[1];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_pc;
  logic [1:0][31:0] in_instr;
  logic [1:0]       can_proceed;
  logic             flush;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_pc;
  logic [1:0][31:0] out_instr;
  logic [1:0]       out_ready;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .can_proceed (can_proceed),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: queue of {instr, pc}, oldest at index 0
  logic [63:0] mq[$];
  logic [1:0]  e_ov, e_cp;
  logic [31:0] e_pc [2];
  logic [31:0] e_in [2];
  logic        m_a0, m_a1;

  task automatic model_eval();
    int sz;
    sz = mq.size();
    e_cp[0] = (sz <= DEPTH - 1);
    e_cp[1] = (sz <= DEPTH - 2);
    m_a0 = in_valid[0] && e_cp[0] && !flush;
    m_a1 = m_a0 && in_valid[1] && e_cp[1];
    e_ov = 2'b00;
    e_pc[0] = 0; e_pc[1] = 0; e_in[0] = 0; e_in[1] = 0;
    if (flush) begin
      e_ov = 2'b00;
    end else if (BYP && sz == 0) begin
      e_ov = {m_a1, m_a0};
      for (int i = 0; i < 2; i++) begin
        e_pc[i] = in_pc[i];
        e_in[i] = in_instr[i];
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sz > i) begin
          e_ov[i] = 1'b1;
          e_pc[i] = mq[i][31:0];
          e_in[i] = mq[i][63:32];
        end
      end
    end
  endtask

  task automatic model_commit();
    logic [63:0] acc[$];
    int take;
    bit was_empty;
    model_eval();
    was_empty = (mq.size() == 0);
    take = 0;
    if (e_ov[0] && out_ready[0]) take = (e_ov[1] && out_ready[1]) ? 2 : 1;
    if (m_a0) acc.push_back({in_instr[0], in_pc[0]});
    if (m_a1) acc.push_back({in_instr[1], in_pc[1]});
    if (flush) begin
      mq.delete();
    end else if (BYP && was_empty) begin
      for (int i = take; i < acc.size(); i++) mq.push_back(acc[i]);
    end else begin
      for (int i = 0; i < take; i++) void'(mq.pop_front());
      foreach (acc[i]) mq.push_back(acc[i]);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic [1:0] iv, input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] rdy, input logic fl);
    in_valid    = iv;
    in_pc[0]    = p0;
    in_pc[1]    = p1;
    in_instr[0] = ~p0 ^ 32'h5A5A_0000;
    in_instr[1] = ~p1 ^ 32'h5A5A_0000;
    out_ready   = rdy;
    flush       = fl;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(2'b00, 0, 0, 2'b00, 1'b0);
    reset = 1'b0;
    mq.delete();
    @(posedge clk);
    #4;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    set_in(2'b11, 32'h40, 32'h44, 2'b11, 1'b0);
    reset = 1'b0;
    mq.delete();
    #3;
    total++;
    if (out_valid !== 2'b00) begin
      bad++; $display("FAIL reset_ov got=%b exp=00", out_valid);
    end
    total++;
    if (can_proceed !== 2'b11) begin
      bad++; $display("FAIL reset_cp got=%b exp=11", can_proceed);
    end
    do_reset();
  endtask

  task automatic test_fill();
    logic [1:0] exp_cp [3];
    exp_cp[0] = 2'b11; exp_cp[1] = 2'b11; exp_cp[2] = 2'b00;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(2'b11, 32'(c * 8), 32'(c * 8 + 4), 2'b00, 1'b0);
      #2;
      total++;
      if (can_proceed !== exp_cp[c]) begin
        bad++; $display("FAIL fill_cp cyc=%0d got=%b exp=%b", c, can_proceed, exp_cp[c]);
      end
      tick();
    end
    set_in(2'b00, 0, 0, 2'b00, 1'b0);
    #2;
    total++;
    if (out_valid !== 2'b11 || out_pc[0] !== 32'h0 || out_pc[1] !== 32'h4) begin
      bad++; $display("FAIL fill_out got=%b %h %h exp=11 0 4", out_valid, out_pc[0], out_pc[1]);
    end
    total++;
    if (mq.size() != 4 || can_proceed !== 2'b00) begin
      bad++; $display("FAIL fill_full cp got=%b exp=00 (model size %0d)", can_proceed, mq.size());
    end
  endtask

  task automatic test_order();
    logic [31:0] got[$];
    int nxt;
    do_reset();
    nxt = 0;
    for (int c = 0; c < 200 && got.size() < 16; c++) begin
      set_in((nxt < 16) ? 2'b11 : 2'b00, 32'(nxt * 4), 32'(nxt * 4 + 4), 2'b01, 1'b0);
      #2;
      model_eval();
      total++;
      if (out_valid !== e_ov) begin
        bad++; $display("FAIL order_ov cyc=%0d got=%b exp=%b", c, out_valid, e_ov);
      end
      if (out_valid[0]) got.push_back(out_pc[0]);
      nxt += int'(m_a0) + int'(m_a1);
      tick();
    end
    total++;
    if (got.size() != 16) begin
      bad++; $display("FAIL order_timeout got=%0d entries exp=16", got.size());
    end
    foreach (got[i]) begin
      total++;
      if (got[i] !== 32'(i * 4)) begin
        bad++; $display("FAIL order_pc idx=%0d got=%h exp=%h", i, got[i], 32'(i * 4));
      end
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(2'b11, 32'h1000 + 32'(c * 8), 32'h1004 + 32'(c * 8), 2'b00, 1'b0);
      tick();
    end
    set_in(2'b11, 32'h2000, 32'h2004, 2'b11, 1'b0);
    #2;
    total++;
    if (can_proceed !== 2'b00 || out_valid !== 2'b11) begin
      bad++; $display("FAIL full_simul_pre cp=%b ov=%b exp cp=00 ov=11", can_proceed, out_valid);
    end
    tick();
    set_in(2'b00, 0, 0, 2'b00, 1'b0);
    #2;
    total++;
    if (can_proceed !== 2'b11 || out_valid !== 2'b11 || out_pc[0] !== 32'h1008) begin
      bad++; $display("FAIL full_simul_post cp=%b ov=%b pc0=%h exp cp=11 ov=11 pc0=00001008",
                      can_proceed, out_valid, out_pc[0]);
    end
  endtask

  task automatic fill_three();
    do_reset();
    set_in(2'b11, 32'h3000, 32'h3004, 2'b00, 1'b0);
    tick();
    set_in(2'b01, 32'h3008, 32'h300C, 2'b00, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    fill_three();
    set_in(2'b11, 32'h3010, 32'h3014, 2'b11, 1'b1);
    #2;
    total++;
    if (out_valid !== 2'b00 || can_proceed !== 2'b01) begin
      bad++; $display("FAIL flush_cycle ov=%b cp=%b exp ov=00 cp=01", out_valid, can_proceed);
    end
    tick();
    set_in(2'b00, 0, 0, 2'b00, 1'b0);
    #2;
    total++;
    if (out_valid !== 2'b00 || can_proceed !== 2'b11) begin
      bad++; $display("FAIL flush_after ov=%b cp=%b exp ov=00 cp=11", out_valid, can_proceed);
    end
  endtask

  task automatic test_reset_mid();
    fill_three();
    set_in(2'b00, 0, 0, 2'b00, 1'b0);
    reset = 1'b0;
    mq.delete();
    #1;
    total++;
    if (out_valid !== 2'b00 || can_proceed !== 2'b11) begin
      bad++; $display("FAIL reset_mid ov=%b cp=%b exp ov=00 cp=11", out_valid, can_proceed);
    end
    #2;
    reset = 1'b1;
    set_in(2'b01, 32'h100, 32'h104, 2'b00, 1'b0);
    tick();
    set_in(2'b00, 0, 0, 2'b00, 1'b0);
    #2;
    total++;
    if (out_valid !== 2'b01 || out_pc[0] !== 32'h100) begin
      bad++; $display("FAIL reset_mid_enq ov=%b pc0=%h exp ov=01 pc0=00000100", out_valid, out_pc[0]);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    set_in(2'b11, 32'h200, 32'h204, 2'b01, 1'b0);
    #2;
`ifdef FETCH_QUEUE_BYPASS_EN
    total++;
    if (out_valid !== 2'b11 || out_pc[0] !== 32'h200) begin
      bad++; $display("FAIL bypass_same ov=%b pc0=%h exp ov=11 pc0=00000200", out_valid, out_pc[0]);
    end
    tick();
    set_in(2'b00, 0, 0, 2'b00, 1'b0);
    #2;
    total++;
    if (out_valid !== 2'b01 || out_pc[0] !== 32'h204) begin
      bad++; $display("FAIL bypass_next ov=%b pc0=%h exp ov=01 pc0=00000204", out_valid, out_pc[0]);
    end
`else
    total++;
    if (out_valid !== 2'b00) begin
      bad++; $display("FAIL nobypass_same ov=%b exp=00", out_valid);
    end
    tick();
    set_in(2'b00, 0, 0, 2'b00, 1'b0);
    #2;
    total++;
    if (out_valid !== 2'b11 || out_pc[0] !== 32'h200) begin
      bad++; $display("FAIL nobypass_next ov=%b pc0=%h exp ov=11 pc0=00000200", out_valid, out_pc[0]);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] pc;
    do_reset();
    pc = 32'h8000;
    for (int c = 0; c < 400; c++) begin
      in_valid     = 2'($urandom_range(0, 3));
      in_pc[0]     = pc;
      in_pc[1]     = pc + 4;
      in_instr[0]  = $urandom;
      in_instr[1]  = $urandom;
      out_ready    = 2'($urandom_range(0, 3));
      flush        = ($urandom_range(0, 15) == 0);
      #2;
      model_eval();
      total++;
      if (out_valid !== e_ov || can_proceed !== e_cp) begin
        bad++; $display("FAIL rnd_ctl cyc=%0d ov=%b cp=%b exp ov=%b cp=%b",
                        c, out_valid, can_proceed, e_ov, e_cp);
      end
      for (int i = 0; i < 2; i++) begin
        if (e_ov[i]) begin
          total++;
          if (out_pc[i] !== e_pc[i] || out_instr[i] !== e_in[i]) begin
            bad++; $display("FAIL rnd_data cyc=%0d slot=%0d got=%h/%h exp=%h/%h",
                            c, i, out_pc[i], out_instr[i], e_pc[i], e_in[i]);
          end
        end
      end
      pc = pc + 32'(4 * (int'(m_a0) + int'(m_a1)));
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    set_in(2'b00, 0, 0, 2'b00, 1'b0);
    #7;
    test_reset();
    test_fill();
    test_order();
    test_full_simul();
    test_flush();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
